// File: rtl/line_clear_ctrl.sv
// Row-clear sequencer for the permanent tetris grid: snapshots the grid, scans bottom-up,
// collapses every full row, then reports the compacted grid, line count and running score.
module line_clear_ctrl #(
    parameter int ROWS    = 22,
    parameter int COLS    = 10,
    parameter int SCORE_W = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [ROWS-1:0][COLS-1:0]      grid_in,
    output logic                           busy,
    output logic                           done,
    output logic [ROWS-1:0][COLS-1:0]      grid_out,
    output logic [$clog2(ROWS+1)-1:0]      lines_cleared,
    output logic [SCORE_W-1:0]             score
);

    localparam int LW    = $clog2(ROWS + 1);
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int SUM_W = ((SCORE_W > LW) ? SCORE_W : LW) + 1;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t                      state_q, state_d;
    logic [RW-1:0]               r_q, r_d;
    logic [LW-1:0]               cnt_q, cnt_d;
    logic [ROWS-1:0][COLS-1:0]   work_q, work_d;
    logic [ROWS-1:0][COLS-1:0]   grid_out_q, grid_out_d;
    logic [LW-1:0]               lines_q, lines_d;
    logic [SCORE_W-1:0]          score_q, score_d;
    logic [ROWS-1:0][COLS-1:0]   shifted;

    // Rows r..1 drop by one, row 0 refills empty, rows below r are untouched.
    function automatic logic [ROWS-1:0][COLS-1:0] shift_down(
        input logic [ROWS-1:0][COLS-1:0] g,
        input logic [RW-1:0]             r
    );
        logic [ROWS-1:0][COLS-1:0] res;
        res    = g;
        res[0] = '0;
        for (int i = 1; i < ROWS; i++) begin
            if (i <= int'(r)) begin
                res[i] = g[i-1];
            end
        end
        return res;
    endfunction

    function automatic logic [SCORE_W-1:0] sat_add(
        input logic [SCORE_W-1:0] a,
        input logic [LW-1:0]      b
    );
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        if (s > SUM_W'(SCORE_MAX)) begin
            return SCORE_MAX;
        end
        return s[SCORE_W-1:0];
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            r_q        <= '0;
            cnt_q      <= '0;
            work_q     <= '0;
            grid_out_q <= '0;
            lines_q    <= '0;
            score_q    <= '0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            grid_out_q <= grid_out_d;
            lines_q    <= lines_d;
            score_q    <= score_d;
        end
    end

    // The SHIFT cycle also evaluates the row that lands at r, so each full row
    // costs exactly one extra cycle and a pass takes ROWS + k cycles.
    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        grid_out_d = grid_out_q;
        lines_d    = lines_q;
        score_d    = score_q;
        shifted    = shift_down(work_q, r_q);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    work_d  = grid_in;
                    r_d     = RW'(ROWS - 1);
                    cnt_d   = '0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (&work_q[r_q]) begin
                    state_d = ST_SHIFT;
                end else if (r_q != '0) begin
                    r_d = r_q - 1'b1;
                end else begin
                    grid_out_d = work_q;
                    lines_d    = cnt_q;
                    state_d    = ST_DONE;
                end
            end
            ST_SHIFT: begin
                work_d = shifted;
                cnt_d  = cnt_q + LW'(1);
                if (&shifted[r_q]) begin
                    state_d = ST_SHIFT;
                end else if (r_q != '0) begin
                    r_d     = r_q - 1'b1;
                    state_d = ST_SCAN;
                end else begin
                    grid_out_d = shifted;
                    lines_d    = cnt_q + LW'(1);
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                score_d = sat_add(score_q, cnt_q);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign grid_out      = grid_out_q;
    assign lines_cleared = lines_q;
    assign score         = score_q;

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Randomized bench for line_clear_ctrl: a 16-bit-score and a 4-bit-score instance share
// stimulus and are compared against a row-list model of full-row removal.
module tb_line_clear_ctrl;

    localparam int ROWS = 22;
    localparam int COLS = 10;
    localparam int LW   = $clog2(ROWS + 1);

    typedef logic [ROWS-1:0][COLS-1:0] grid_t;

    logic           clk;
    logic           reset;
    logic           start;
    grid_t          grid_in;
    logic           busy, busy4;
    logic           done, done4;
    grid_t          grid_out, grid_out4;
    logic [LW-1:0]  lines, lines4;
    logic [15:0]    score16;
    logic [3:0]     score4;

    int n_chk;
    int n_fail;
    int exp_s16;
    int exp_s4;

    line_clear_ctrl #(.ROWS(ROWS), .COLS(COLS), .SCORE_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .grid_in(grid_in),
        .busy(busy), .done(done), .grid_out(grid_out),
        .lines_cleared(lines), .score(score16)
    );

    line_clear_ctrl #(.ROWS(ROWS), .COLS(COLS), .SCORE_W(4)) dut4 (
        .clk(clk), .reset(reset), .start(start), .grid_in(grid_in),
        .busy(busy4), .done(done4), .grid_out(grid_out4),
        .lines_cleared(lines4), .score(score4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Full rows vanish; the surviving rows keep their order and settle at the bottom.
    task automatic model_clear(input grid_t g, output grid_t o, output int k);
        logic [COLS-1:0] keep[$];
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (g[i] != '1) keep.push_back(g[i]);
        end
        k = ROWS - keep.size();
        o = '0;
        for (int j = 0; j < keep.size(); j++) o[ROWS-1-j] = keep[j];
    endtask

    function automatic grid_t rand_grid(input int full_pct);
        grid_t g;
        for (int i = 0; i < ROWS; i++) begin
            if ($urandom_range(0, 99) < full_pct) g[i] = '1;
            else g[i] = COLS'($urandom_range(0, (1 << COLS) - 2));
        end
        return g;
    endfunction

    // Drives one pass; extra != 0 pulses start again at that busy cycle and in the done cycle.
    task automatic run_pass(input grid_t g, input int extra);
        grid_t exp_g;
        int    k;
        int    n;
        bit    got;
        int    pulses;
        model_clear(g, exp_g, k);
        grid_in = g;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        grid_in = rand_grid(50);
        n   = 0;
        got = 1'b0;
        while (n < 200 && !got) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) chk("busy_after_start", {busy, busy4}, 2'b11);
            if (done) begin
                got   = 1'b1;
                start = (extra != 0);
            end else begin
                start = (extra != 0 && n == extra);
                grid_in = rand_grid(50);
            end
        end
        chk("latency", n, ROWS + k);
        chk("done4_aligned", done4, 1'b1);
        chk("lines", lines, k);
        chk("lines4", lines4, k);
        chk("grid_out", grid_out, exp_g);
        chk("grid_out4", grid_out4, exp_g);
        exp_s16 = (exp_s16 + k > 65535) ? 65535 : exp_s16 + k;
        exp_s4  = (exp_s4 + k > 15) ? 15 : exp_s4 + k;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("score16", score16, exp_s16);
        chk("score4", score4, exp_s4);
        chk("idle_after_done", {busy, done, busy4, done4}, 4'b0000);
        chk("lines_held", lines, k);
        if (extra != 0) begin
            pulses = 0;
            for (int c = 0; c < 30; c++) begin
                @(posedge clk);
                #1;
                if (done || done4 || busy) pulses++;
            end
            chk("start_not_queued", pulses, 0);
        end
    endtask

    initial begin
        grid_t g;
        grid_t tmp;
        int    kk;
        int    seen;
        n_chk   = 0;
        n_fail  = 0;
        exp_s16 = 0;
        exp_s4  = 0;
        reset   = 1'b1;
        start   = 1'b0;
        grid_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy_done", {busy, done, busy4, done4}, 4'b0000);
        chk("rst_grid_out", grid_out, '0);
        chk("rst_lines", lines, 0);
        chk("rst_score", score16, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Empty grid
        run_pass('0, 0);

        // Single full bottom row
        g = '0;
        g[21] = 10'h3FF;
        g[20] = 10'h001;
        run_pass(g, 0);
        chk("t3_row21", grid_out[21], 10'h001);
        chk("t3_score", score16, 1);

        // Four full rows under a nearly-full row
        g = '0;
        for (int i = 18; i < 22; i++) g[i] = 10'h3FF;
        g[17] = 10'h3FE;
        run_pass(g, 0);
        chk("t4_row21", grid_out[21], 10'h3FE);
        chk("t4_score", score16, 5);

        // Interleaved full rows, with a redundant start while busy
        g = '0;
        g[21] = 10'h3FF;
        g[20] = 10'h155;
        g[19] = 10'h3FF;
        g[18] = 10'h2AA;
        run_pass(g, 4);
        chk("t5_rows", {grid_out[21], grid_out[20]}, {10'h155, 10'h2AA});

        // Every row full, drives the 4-bit score into saturation
        g = '1;
        run_pass(g, 0);
        chk("t6_score4_sat", score4, 4'hF);

        // Row 0 full together with random content
        g = rand_grid(30);
        g[0] = '1;
        run_pass(g, 0);

        for (int t = 0; t < 8; t++) begin
            run_pass(rand_grid(t * 12), (t % 3 == 0) ? 1 + t : 0);
        end

        // Reset in the middle of a pass
        g = rand_grid(40);
        grid_in = g;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("t1_busy_done", {busy, done, busy4, done4}, 4'b0000);
        chk("t1_grid_out", grid_out, '0);
        chk("t1_lines", lines, 0);
        chk("t1_score", {score16, score4}, 0);
        repeat (3) @(posedge clk);
        #1;
        reset   = 1'b0;
        exp_s16 = 0;
        exp_s4  = 0;
        seen    = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        chk("t1_no_done", seen, 0);

        g = rand_grid(35);
        model_clear(g, tmp, kk);
        run_pass(g, 0);
        chk("post_reset_score", score16, kk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
